// File: rtl/hp_pkg.sv
// Shared binary16 constants and types for the half-precision datapath.
// Used by the operand classifier and the iterative divider.
package hp_pkg;

  typedef logic signed [6:0] exp_t;

  localparam exp_t EXP_BIAS = 7'sd15;
  localparam exp_t EMIN     = -7'sd14;
  localparam exp_t EMAX     = 7'sd15;
  localparam exp_t SUB_MIN  = -7'sd24;

  localparam logic [8:0] QNAN_DEFAULT = 9'h2A;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DIV,
    PACK
  } state_t;

  typedef struct packed {
    logic snan;
    logic qnan;
    logic infinity;
    logic zero;
    logic subnormal;
    logic normal;
  } flags_t;

  // Highest set bit wins; callers never pass zero.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/hp_div_if.sv
// Start/busy/done handshake bundle for the binary16 divider.
// Master issues operands, slave returns quotient and class.
interface hp_div_if;

  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic        snan;
  logic        qnan;
  logic        infinity;
  logic        zero;
  logic        subnormal;
  logic        normal;
  logic        div_by_zero;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  q,
    input  snan,
    input  qnan,
    input  infinity,
    input  zero,
    input  subnormal,
    input  normal,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output q,
    output snan,
    output qnan,
    output infinity,
    output zero,
    output subnormal,
    output normal,
    output div_by_zero
  );

endinterface

// File: rtl/hp_class.sv
// Binary16 operand decode: sign, unbiased exponent, significand, class.
// Subnormals report EMIN with a zero hidden bit.
module hp_class
  import hp_pkg::*;
(
  input  logic [15:0] x,
  output logic        sign,
  output exp_t        expo,
  output logic [10:0] sig,
  output logic        isSnan,
  output logic        isQnan,
  output logic        isInf,
  output logic        isZero
);

  logic [4:0] ef;
  logic [9:0] fr;
  logic       expMax;
  logic       expMin;
  logic       frNz;

  assign ef     = x[14:10];
  assign fr     = x[9:0];
  assign expMax = (ef == 5'h1F);
  assign expMin = (ef == 5'h00);
  assign frNz   = (fr != 10'h000);

  assign sign   = x[15];
  assign isZero = expMin & ~frNz;
  assign isInf  = expMax & ~frNz;
  assign isQnan = expMax & fr[9];
  assign isSnan = expMax & ~fr[9] & frNz;
  assign sig    = {~expMin, fr};
  assign expo   = expMin ? EMIN
                         : exp_t'({2'b00, ef}) - EXP_BIAS;

endmodule

// File: rtl/hp_div.sv
// Iterative binary16 divider, one restoring quotient bit per clock.
// Specials resolve at accept; truncating pack into one-hot class.
module hp_div
  import hp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  hp_div_if.slave  bus
);

  state_t state;
  state_t stateNxt;

  logic        aSign, bSign;
  exp_t        aExp, bExp;
  logic [10:0] aSig, bSig;
  logic        aSnan, bSnan;
  logic        aQnan, bQnan;
  logic        aInf, bInf;
  logic        aZero, bZero;

  hp_class uClassA (
    .x      (bus.a),
    .sign   (aSign),
    .expo   (aExp),
    .sig    (aSig),
    .isSnan (aSnan),
    .isQnan (aQnan),
    .isInf  (aInf),
    .isZero (aZero)
  );

  hp_class uClassB (
    .x      (bus.b),
    .sign   (bSign),
    .expo   (bExp),
    .sig    (bSig),
    .isSnan (bSnan),
    .isQnan (bQnan),
    .isInf  (bInf),
    .isZero (bZero)
  );

  logic        accept;
  logic        sgn;
  logic        specIn;
  logic        specDbz;
  logic [15:0] specQ;
  flags_t      specFl;

  assign accept = (state == IDLE) & bus.start;
  assign sgn    = aSign ^ bSign;

  always_comb begin
    specIn  = 1'b1;
    specDbz = 1'b0;
    specQ   = 16'h0000;
    specFl  = '0;
    priority case (1'b1)
      aSnan | bSnan: begin
        specQ       = aSnan ? bus.a : bus.b;
        specFl.snan = 1'b1;
      end
      aQnan | bQnan: begin
        specQ       = aQnan ? bus.a : bus.b;
        specFl.qnan = 1'b1;
      end
      (aInf & bInf) | (aZero & bZero): begin
        specQ       = {sgn, 5'h1F, 1'b1, QNAN_DEFAULT};
        specFl.qnan = 1'b1;
      end
      aInf: begin
        specQ           = {sgn, 5'h1F, 10'h000};
        specFl.infinity = 1'b1;
      end
      bInf: begin
        specQ       = {sgn, 15'h0000};
        specFl.zero = 1'b1;
      end
      bZero: begin
        specQ           = {sgn, 5'h1F, 10'h000};
        specFl.infinity = 1'b1;
        specDbz         = 1'b1;
      end
      aZero: begin
        specQ       = {sgn, 15'h0000};
        specFl.zero = 1'b1;
      end
      default: specIn = 1'b0;
    endcase
  end

  logic        signR;
  exp_t        eaR, ebR, eR;
  logic [10:0] saR, sbR;
  logic [11:0] rem, quo;
  logic [3:0]  cnt;
  logic        specR, specDbzR;
  logic [15:0] specQR;
  flags_t      specFlR;
  logic [15:0] qR;
  flags_t      flR;
  logic        dbzR;
  logic        doneR;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (bus.start) stateNxt = specIn ? PACK : NORM;
      NORM:    stateNxt = DIV;
      DIV:     if (cnt == 4'd11) stateNxt = PACK;
      PACK:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  logic [3:0] lzA, lzB;

  assign lzA = lzc11(saR);
  assign lzB = lzc11(sbR);

  logic        remGe;
  logic [11:0] remNxt;

  assign remGe  = rem >= {1'b0, sbR};
  assign remNxt = remGe ? rem - {1'b0, sbR} : rem;

  logic [10:0] pSig;
  exp_t        pE;
  logic [15:0] packQ;
  flags_t      packFl;

  // Quotient lies in (0.5, 2): the top bit picks the normalizing shift.
  always_comb begin
    pSig   = quo[11] ? quo[11:1] : quo[10:0];
    pE     = quo[11] ? eR : eR - 7'sd1;
    packQ  = {signR, 15'h0000};
    packFl = '0;
    if (pE < SUB_MIN) begin
      packFl.zero = 1'b1;
    end else if (pE < EMIN) begin
      packQ            = {signR, 5'b00000, 10'(pSig >> (EMIN - pE))};
      packFl.subnormal = 1'b1;
    end else if (pE > EMAX) begin
      packQ           = {signR, 5'h1F, 10'h000};
      packFl.infinity = 1'b1;
    end else begin
      packQ         = {signR, 5'(pE + EXP_BIAS), pSig[9:0]};
      packFl.normal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signR    <= 1'b0;
      eaR      <= '0;
      ebR      <= '0;
      eR       <= '0;
      saR      <= '0;
      sbR      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      specR    <= 1'b0;
      specDbzR <= 1'b0;
      specQR   <= '0;
      specFlR  <= '0;
      qR       <= '0;
      flR      <= '0;
      dbzR     <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            signR    <= sgn;
            eaR      <= aExp;
            ebR      <= bExp;
            saR      <= aSig;
            sbR      <= bSig;
            specR    <= specIn;
            specDbzR <= specDbz;
            specQR   <= specQ;
            specFlR  <= specFl;
          end
        end
        NORM: begin
          eR  <= (eaR - exp_t'({3'b000, lzA}))
               - (ebR - exp_t'({3'b000, lzB}));
          rem <= {1'b0, saR << lzA};
          sbR <= sbR << lzB;
          quo <= '0;
          cnt <= '0;
        end
        DIV: begin
          rem <= remNxt << 1;
          quo <= {quo[10:0], remGe};
          cnt <= cnt + 4'd1;
        end
        PACK: begin
          qR    <= specR ? specQR : packQ;
          flR   <= specR ? specFlR : packFl;
          dbzR  <= specR & specDbzR;
          doneR <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = doneR;
  assign bus.q           = qR;
  assign bus.snan        = flR.snan;
  assign bus.qnan        = flR.qnan;
  assign bus.infinity    = flR.infinity;
  assign bus.zero        = flR.zero;
  assign bus.subnormal   = flR.subnormal;
  assign bus.normal      = flR.normal;
  assign bus.div_by_zero = dbzR;

endmodule

// File: tb/tb_hp_div.sv
// Bench for hp_div: directed vectors, handshake cases and random
// operands against an exact integer-ratio truncation model.
module tb_hp_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hp_div_if bus ();

  hp_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] dA [10] = '{16'h4200, 16'h3C00, 16'hC400, 16'h0001,
                           16'h0400, 16'h7BFF, 16'h3C00, 16'h0000,
                           16'h7D00, 16'h7C00};
  logic [15:0] dB [10] = '{16'h4000, 16'h4200, 16'h3800, 16'h3C00,
                           16'h4000, 16'h0001, 16'h0000, 16'h0000,
                           16'h7E00, 16'h4000};
  logic [15:0] dQ [10] = '{16'h3E00, 16'h3555, 16'hC800, 16'h0001,
                           16'h0200, 16'h7C00, 16'h7C00, 16'h7E2A,
                           16'h7D00, 16'h7C00};
  logic [5:0]  dF [10] = '{6'b000001, 6'b000001, 6'b000001, 6'b000010,
                           6'b000010, 6'b001000, 6'b001000, 6'b010000,
                           6'b100000, 6'b001000};
  logic        dZ [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int          dL [10] = '{14, 14, 14, 14, 14, 14, 1, 1, 1, 1};

  function automatic logic [5:0] obsFlags();
    return {bus.snan, bus.qnan, bus.infinity,
            bus.zero, bus.subnormal, bus.normal};
  endfunction

  // Class of a binary16 value from its bit pattern alone.
  function automatic logic [5:0] refClass(input logic [15:0] v);
    if (v[14:10] == 5'h1F) begin
      if (v[9:0] == 10'h000) return 6'b001000;
      if (v[9])              return 6'b010000;
      return 6'b100000;
    end
    if (v[14:10] == 5'h00) begin
      if (v[9:0] == 10'h000) return 6'b000100;
      return 6'b000010;
    end
    return 6'b000001;
  endfunction

  // Value = m * 2^x; result is floor(a/b in units of 2^-24), then encoded.
  task automatic refDiv(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic dbz,
                        output logic spec);
    logic sgn, aN, bN, aSn, bSn, aQn, bQn, aI, bI, aZ, bZ;
    logic [10:0] ma, mb;
    logic [127:0] num, den, n, m;
    int xa, xb, k, p;
    sgn = a[15] ^ b[15];
    aN  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    bN  = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    aSn = aN && !a[9];
    bSn = bN && !b[9];
    aQn = aN && a[9];
    bQn = bN && b[9];
    aI  = (a[14:0] == 15'h7C00);
    bI  = (b[14:0] == 15'h7C00);
    aZ  = (a[14:0] == 15'h0000);
    bZ  = (b[14:0] == 15'h0000);
    dbz  = 1'b0;
    spec = 1'b1;
    q    = 16'h0000;
    if (aSn || bSn)                   q = aSn ? a : b;
    else if (aQn || bQn)              q = aQn ? a : b;
    else if ((aI && bI) || (aZ && bZ)) q = {sgn, 15'h7E2A};
    else if (aI)                      q = {sgn, 15'h7C00};
    else if (bI)                      q = {sgn, 15'h0000};
    else if (bZ) begin
      q   = {sgn, 15'h7C00};
      dbz = 1'b1;
    end else if (aZ)                  q = {sgn, 15'h0000};
    else begin
      spec = 1'b0;
      if (a[14:10] == 0) begin ma = {1'b0, a[9:0]}; xa = -24; end
      else begin ma = {1'b1, a[9:0]}; xa = int'(a[14:10]) - 25; end
      if (b[14:10] == 0) begin mb = {1'b0, b[9:0]}; xb = -24; end
      else begin mb = {1'b1, b[9:0]}; xb = int'(b[14:10]) - 25; end
      k = xa - xb + 24;
      if (k >= 0) begin
        num = 128'(ma) << k;
        den = 128'(mb);
      end else begin
        num = 128'(ma);
        den = 128'(mb) << (-k);
      end
      n = num / den;
      if (n == 0) q = {sgn, 15'h0000};
      else if (n < 1024) q = {sgn, 5'd0, n[9:0]};
      else begin
        p = 0;
        for (int i = 0; i < 128; i++) if (n[i]) p = i;
        if (p - 24 > 15) q = {sgn, 15'h7C00};
        else begin
          m = n >> (p - 10);
          q = {sgn, 5'(p - 9), m[9:0]};
        end
      end
    end
  endtask

  task automatic runDiv(input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.q !== 16'h0000) begin
      errors++; $display("FAIL reset_q got=%h want=0000", bus.q);
    end
    checks++;
    if (obsFlags() !== 6'b000000) begin
      errors++; $display("FAIL reset_flags got=%b want=000000", obsFlags());
    end
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_busy_window();
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h4200;
    bus.b = 16'h4000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != 14) begin
      errors++; $display("FAIL busy_cycles got=%0d want=14", n);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL busy_end_done got=%b want=1", bus.done);
    end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 10; i++) begin
      runDiv(dA[i], dB[i], lat);
      checks++;
      if (lat != dL[i]) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, dL[i]);
      end
      checks++;
      if (bus.q !== dQ[i]) begin
        errors++;
        $display("FAIL dir%0d_q %h/%h got=%h want=%h",
                 i, dA[i], dB[i], bus.q, dQ[i]);
      end
      checks++;
      if (obsFlags() !== dF[i]) begin
        errors++;
        $display("FAIL dir%0d_flags got=%b want=%b", i, obsFlags(), dF[i]);
      end
      checks++;
      if (bus.div_by_zero !== dZ[i]) begin
        errors++;
        $display("FAIL dir%0d_dbz got=%b want=%b",
                 i, bus.div_by_zero, dZ[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, eq;
    logic edbz, espec;
    int lat;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = {1'($urandom), 5'($urandom_range(0, 22)), 10'($urandom)};
        b = {1'($urandom), 5'($urandom_range(0, 22)), 10'($urandom)};
      end
      refDiv(a, b, eq, edbz, espec);
      runDiv(a, b, lat);
      checks++;
      if (lat != (espec ? 1 : 14)) begin
        errors++;
        $display("FAIL rnd%0d_latency %h/%h got=%0d want=%0d",
                 i, a, b, lat, espec ? 1 : 14);
      end
      checks++;
      if (bus.q !== eq) begin
        errors++;
        $display("FAIL rnd%0d_q %h/%h got=%h want=%h", i, a, b, bus.q, eq);
      end
      checks++;
      if (obsFlags() !== refClass(eq)) begin
        errors++;
        $display("FAIL rnd%0d_flags %h/%h got=%b want=%b",
                 i, a, b, obsFlags(), refClass(eq));
      end
      checks++;
      if (bus.div_by_zero !== edbz) begin
        errors++;
        $display("FAIL rnd%0d_dbz %h/%h got=%b want=%b",
                 i, a, b, bus.div_by_zero, edbz);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h4200;
    bus.b = 16'h4000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h3C00;
        bus.b = 16'h0000;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL busy_start_latency got=%0d want=14", lat);
    end
    checks++;
    if (bus.q !== 16'h3E00) begin
      errors++; $display("FAIL busy_start_q got=%h want=3e00", bus.q);
    end
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_dbz got=%b want=0", bus.div_by_zero);
    end
    extra = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL busy_start_queued got=%0d want=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    runDiv(16'h4200, 16'h4000, lat);
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL b2b_first_latency got=%0d want=14", lat);
    end
    bus.start = 1'b1;
    bus.a = 16'hC400;
    bus.b = 16'h3800;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got=%b want=1", bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 14) begin
      errors++; $display("FAIL b2b_second_latency got=%0d want=14", lat);
    end
    checks++;
    if (bus.q !== 16'hC800) begin
      errors++; $display("FAIL b2b_q got=%h want=c800", bus.q);
    end
    checks++;
    if (obsFlags() !== 6'b000001) begin
      errors++; $display("FAIL b2b_flags got=%b want=000001", obsFlags());
    end
  endtask

  task automatic test_reset_mid();
    int seen, lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h3C00;
    bus.b = 16'h4200;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.q !== 16'h0000) begin
      errors++; $display("FAIL midrst_q got=%h want=0000", bus.q);
    end
    checks++;
    if (obsFlags() !== 6'b000000) begin
      errors++; $display("FAIL midrst_flags got=%b want=000000", obsFlags());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_done got=%0d want=0", seen);
    end
    checks++;
    if (bus.q !== 16'h0000) begin
      errors++; $display("FAIL midrst_q_hold got=%h want=0000", bus.q);
    end
    runDiv(16'h4200, 16'h4000, lat);
    checks++;
    if (bus.q !== 16'h3E00 || lat != 14) begin
      errors++;
      $display("FAIL midrst_recover got=%h/%0d want=3e00/14", bus.q, lat);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    test_reset();
    test_busy_window();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
